// File: rtl/burst_line_writer_pkg.sv
// Shared constants and types for the burst line writer: BurstRAM command codes,
// FSM state encoding and the byte-offset helpers used to align line addresses.
package burst_line_writer_pkg;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

  localparam int STAT_BITWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RAM = 2'd1,
    ST_BURST    = 2'd2,
    ST_DONE     = 2'd3
  } blw_state_e;

  // Number of low address bits that select a byte inside a block of 'bits' bits.
  function automatic int byte_offset_bits(input int bits);
    return $clog2(bits / 8);
  endfunction

  // Offsets for the default geometry: 64-bit beats, 4 beats per line.
  localparam int DEFAULT_BEAT_OFFSET_BITS = 3;
  localparam int DEFAULT_LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/burst_line_writer.sv
// Buffers one cache line with byte enables and issues it to BurstRAM as a single
// write burst, one beat per cycle, then pulses done and counts the written line.
module burst_line_writer
  import burst_line_writer_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH        = 32,
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   enable,
  input  logic [ADDRESS_BITWIDTH-1:0]                            address,
  input  logic [RAM_BURST_DATA_BITWIDTH*RAM_BURST_DATA_COUNT-1:0]  line_data,
  input  logic [RAM_BURST_DATA_BITWIDTH*RAM_BURST_DATA_COUNT/8-1:0] line_byte_en,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   br_cmd,
  output logic                                                   br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]                          br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]                     br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]                   br_data_mask,
  input  logic                                                   br_busy,
  output logic [STAT_BITWIDTH-1:0]                               stat_lines_written
);

  localparam int W          = RAM_BURST_DATA_BITWIDTH;
  localparam int N          = RAM_BURST_DATA_COUNT;
  localparam int BEAT_BYTES = W / 8;
  localparam int LINE_BITS  = W * N;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int BEAT_OFF   = byte_offset_bits(W);
  localparam int LINE_OFF   = byte_offset_bits(LINE_BITS);
  localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;

  localparam logic [ADDRESS_BITWIDTH-1:0] LINE_MASK =
    (ADDRESS_BITWIDTH'(1) << LINE_OFF) - ADDRESS_BITWIDTH'(1);

  blw_state_e state_q, state_d;

  logic [ADDRESS_BITWIDTH-1:0] line_addr_q;
  logic [LINE_BITS-1:0]        line_data_q;
  logic [LINE_BYTES-1:0]       line_be_q;
  logic [CNT_W-1:0]            beat_cnt_q;
  logic [STAT_BITWIDTH-1:0]    stat_q;

  logic             accept;
  logic             line_empty;
  logic             issue;
  logic             last_beat;
  logic             beat_active;
  logic [CNT_W-1:0] beat_idx;

  // A new request may also be taken in the DONE cycle, giving back-to-back lines.
  assign accept     = enable && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign line_empty = ~|line_byte_en;
  assign issue      = (state_q == ST_WAIT_RAM) && !br_busy;
  assign last_beat  = (state_q == ST_BURST) && (beat_cnt_q == CNT_W'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = line_empty ? ST_DONE : ST_WAIT_RAM;
      end
      ST_WAIT_RAM: begin
        if (!br_busy) state_d = (N == 1) ? ST_DONE : ST_BURST;
      end
      ST_BURST: begin
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (enable) state_d = line_empty ? ST_DONE : ST_WAIT_RAM;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the line buffer holds no state that matters while idle, so it carries
  // no reset; only control state and the counters are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_addr_q <= address & ~LINE_MASK;
      line_data_q <= line_data;
      line_be_q   <= line_byte_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      stat_q     <= '0;
    end else begin
      if (issue)
        beat_cnt_q <= CNT_W'(1);
      else if (state_q == ST_BURST)
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
      if (state_q == ST_DONE)
        stat_q <= stat_q + STAT_BITWIDTH'(1);
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    br_cmd       = BR_CMD_READ;
    br_cmd_en    = 1'b0;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    beat_active  = 1'b0;
    beat_idx     = '0;
    unique case (state_q)
      ST_WAIT_RAM: begin
        busy = 1'b1;
        if (!br_busy) begin
          beat_active = 1'b1;
          br_cmd_en   = 1'b1;
        end
      end
      ST_BURST: begin
        busy        = 1'b1;
        beat_active = 1'b1;
        beat_idx    = beat_cnt_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (beat_active) begin
      br_cmd       = BR_CMD_WRITE;
      // Addresses above the RAM depth wrap; the burst-index bits are already zero.
      br_addr      = RAM_DEPTH_BITWIDTH'(line_addr_q >> BEAT_OFF);
      br_wr_data   = line_data_q[beat_idx*W +: W];
      br_data_mask = ~line_be_q[beat_idx*BEAT_BYTES +: BEAT_BYTES];
    end
  end

  assign stat_lines_written = stat_q;

endmodule

// File: tb/tb_burst_line_writer.sv
// Scoreboard bench for burst_line_writer: tests queue expected beats and done
// pulses; a negedge monitor compares them and maintains a small BurstRAM image.
module tb_burst_line_writer;
  import burst_line_writer_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [31:0]  address;
  logic [255:0] line_data;
  logic [31:0]  line_byte_en;
  logic         busy, done, br_cmd, br_cmd_en;
  logic [3:0]   br_addr;
  logic [63:0]  br_wr_data;
  logic [7:0]   br_data_mask;
  logic         br_busy;
  logic [31:0]  stat_lines_written;

  always #5 clk = ~clk;

  burst_line_writer dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address),
    .line_data(line_data), .line_byte_en(line_byte_en),
    .busy(busy), .done(done), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_busy(br_busy), .stat_lines_written(stat_lines_written)
  );

  typedef struct {
    logic        first;
    logic [3:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  typedef struct {
    int acc;
    int lat;
    int stat;
  } done_t;

  beat_t       beat_q[$];
  done_t       done_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          exp_stat = 0;
  logic [63:0] mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops one expected beat per driven beat and one entry per done pulse.
  int         remaining = 0;
  int         beat_i    = 0;
  logic [3:0] cur_addr  = '0;
  always @(negedge clk) begin
    beat_t      e;
    done_t      d;
    logic [3:0] idx;
    if (rst) begin
      remaining = 0;
    end else begin
      if (br_cmd_en || remaining > 0) begin
        if (br_cmd_en) begin
          cur_addr  = br_addr;
          beat_i    = 0;
          remaining = N - 1;
        end else begin
          beat_i++;
          remaining--;
        end
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = beat_q.pop_front();
          check("beat_cmd_en", 64'(br_cmd_en), 64'(e.first));
          if (e.first) begin
            check("br_cmd", 64'(br_cmd), 64'(BR_CMD_WRITE));
            check("br_addr", 64'(br_addr), 64'(e.addr));
          end
          check("beat_data", br_wr_data, e.data);
          check("beat_mask", 64'(br_data_mask), 64'(e.mask));
        end
        idx = cur_addr + 4'(beat_i);
        for (int b = 0; b < 8; b++)
          if (!br_data_mask[b]) mem[idx][b*8 +: 8] = br_wr_data[b*8 +: 8];
      end else begin
        check("idle_data", br_wr_data, 64'd0);
        check("idle_mask", 64'(br_data_mask), 64'd0);
      end
      if (done) begin
        check("busy_in_done", 64'(busy), 64'd0);
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          d = done_q.pop_front();
          check("done_latency", 64'(cyc - d.acc), 64'(d.lat));
          check("stat_at_done", 64'(stat_lines_written), 64'(d.stat));
        end
      end
    end
  end

  task automatic push_burst(input logic [3:0] a, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3, input logic [31:0] masks);
    beat_q.push_back('{first: 1'b1, addr: a, data: d0, mask: masks[7:0]});
    beat_q.push_back('{first: 1'b0, addr: a, data: d1, mask: masks[15:8]});
    beat_q.push_back('{first: 1'b0, addr: a, data: d2, mask: masks[23:16]});
    beat_q.push_back('{first: 1'b0, addr: a, data: d3, mask: masks[31:24]});
  endtask

  // Presents a request for one edge once the writer is free; lat is counted from
  // the cycle enable is presented to the cycle done is seen.
  task automatic issue(input logic [31:0] a, input logic [255:0] ld, input logic [31:0] be,
                       input int lat);
    int g = 0;
    @(negedge clk);
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy) check("issue_timeout", 64'd1, 64'd0);
    address      = a;
    line_data    = ld;
    line_byte_en = be;
    enable       = 1'b1;
    done_q.push_back('{acc: cyc, lat: lat, stat: exp_stat});
    exp_stat++;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || done || beat_q.size() != 0 || done_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst          = 1'b1;
    enable       = 1'b0;
    address      = '0;
    line_data    = '0;
    line_byte_en = '0;
    br_busy      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cmd", 64'({br_cmd, br_cmd_en}), 64'd0);
    check("rst_addr", 64'(br_addr), 64'd0);
    check("rst_data", br_wr_data, 64'd0);
    check("rst_mask", 64'(br_data_mask), 64'd0);
    check("rst_stat", 64'(stat_lines_written), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full line at 32: word 4, no bytes masked.
    push_burst(4'd4, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 32'h0000_0000);
    issue(32'd32, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'hFFFF_FFFF, 5);
    wait_idle();
    check("mem4_full", mem[4], 64'h1111_1111_1111_1111);
    check("mem7_full", mem[7], 64'h4444_4444_4444_4444);

    // Unaligned 36, only bytes 0-3 of beat 0 enabled.
    push_burst(4'd4, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 32'hFFFF_FFF0);
    issue(32'd36, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 32'h0000_000F, 5);
    wait_idle();
    check("mem4_partial", mem[4], 64'h1111_1111_AAAA_AAAA);
    check("mem5_untouched", mem[5], 64'h2222_2222_2222_2222);

    // BurstRAM busy for 5 cycles after accept: command waits, beats then back to back.
    br_busy = 1'b1;
    push_burst(4'd8, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 32'h0000_0000);
    issue(32'd64, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                   64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}, 32'hFFFF_FFFF, 10);
    repeat (5) begin
      @(negedge clk);
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_cmd_en", 64'(br_cmd_en), 64'd0);
    end
    @(posedge clk);
    #1 br_busy = 1'b0;
    wait_idle();
    check("mem11_after_stall", mem[11], 64'h8888_8888_8888_8888);

    // Address 0x1E5 wraps to word 12; a second enable while busy is ignored.
    push_burst(4'd12, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 32'h00FF_00FF);
    issue(32'h0000_01E5, {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                          64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 32'hFF00_FF00, 5);
    @(negedge clk);
    address      = 32'd64;
    line_data    = {4{64'hDEAD_BEEF_DEAD_BEEF}};
    line_byte_en = 32'hFFFF_FFFF;
    enable       = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check("mem12_masked", mem[12], 64'd0);
    check("mem13_written", mem[13], 64'hFEDC_BA98_7654_3210);
    check("stat_after_ignored", 64'(stat_lines_written), 64'd4);

    // All byte enables zero: no command, done one cycle after accept, still counted.
    issue(32'h0000_0100, {4{64'h5A5A_5A5A_5A5A_5A5A}}, 32'h0000_0000, 1);
    wait_idle();
    check("stat_zero_en", 64'(stat_lines_written), 64'd5);

    // Back-to-back lines: second accepted in the first one's DONE cycle.
    push_burst(4'd0, 64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
               64'h3030_3030_3030_3030, 64'h4040_4040_4040_4040, 32'hF0F0_F0F0);
    push_burst(4'd4, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0B0B_0B0B_0B0B_0B0B,
               64'h0C0C_0C0C_0C0C_0C0C, 64'h0D0D_0D0D_0D0D_0D0D, 32'h0000_0000);
    issue(32'd0, {64'h4040_4040_4040_4040, 64'h3030_3030_3030_3030,
                  64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010}, 32'h0F0F_0F0F, 5);
    issue(32'd32, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                   64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}, 32'hFFFF_FFFF, 5);
    wait_idle();
    check("mem0_b2b", mem[0], 64'h0000_0000_1010_1010);
    check("stat_b2b", 64'(stat_lines_written), 64'd7);

    // Reset after beat 1 of a burst.
    push_burst(4'd8, 64'h7A7A_7A7A_7A7A_7A7A, 64'h7B7B_7B7B_7B7B_7B7B,
               64'h7C7C_7C7C_7C7C_7C7C, 64'h7D7D_7D7D_7D7D_7D7D, 32'h0000_0000);
    issue(32'd64, {64'h7D7D_7D7D_7D7D_7D7D, 64'h7C7C_7C7C_7C7C_7C7C,
                   64'h7B7B_7B7B_7B7B_7B7B, 64'h7A7A_7A7A_7A7A_7A7A}, 32'hFFFF_FFFF, 5);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_cmd_en", 64'(br_cmd_en), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_data", br_wr_data, 64'd0);
    check("midrst_stat", 64'(stat_lines_written), 64'd0);
    beat_q.delete();
    done_q.delete();
    exp_stat = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Recovery after reset: address 63 aligns down to word 4.
    push_burst(4'd4, 64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
               64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004, 32'h0000_0000);
    issue(32'd63, {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
                   64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001}, 32'hFFFF_FFFF, 5);
    wait_idle();
    check("stat_final", 64'(stat_lines_written), 64'd1);
    check("mem6_recovery", mem[6], 64'hC0DE_0000_0000_0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
